seg7_scan_driver: RTL
=====================

# seg7_scan_driver

Time-multiplexed driver for an N-digit common-anode 7-segment display. It generalises the single-digit BCD decoder to multiple digits, with hex or decimal glyphs, per-digit decimal points, leading-zero blanking, frame-synchronous value update and an anti-ghosting guard interval. It sits between the tester's result/status registers and the board's segment and anode pins.

## Interface
- `NUM_DIGITS`, 4: digits driven (1..8).
- `SCAN_DIV`, 50000: clock cycles per digit slot (≥ 2·`GUARD`+1).
- `GUARD`, 2: cycles at the start of each slot during which all anodes are off.
- `HEX_MODE`, 1: 1 = nibbles 10..15 show A,b,C,d,E,F; 0 = nibbles 10..15 show the error glyph E.
- `clk` in 1: system clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `value` in 4·`NUM_DIGITS`: nibble k is digit k; digit 0 is rightmost/least significant.
- `dp_in` in `NUM_DIGITS`: decimal point request per digit; 1 = lit.
- `load` in 1: one-cycle strobe that captures `value` and `dp_in`.
- `blank_lz` in 1: 1 = blank leading zeros.
- `enable` in 1: 0 = all anodes off; scanning continues.
- `seg` out 7: segments g..a (bit6..bit0), active-low.
- `dp` out 1: decimal point, active-low.
- `an` out `NUM_DIGITS`: anode select, active-low, one-hot-low when on.
- `frame_start` out 1: one-cycle pulse when digit 0's slot begins.

## Operation
- Glyphs (g..a, active-low): 0 1000000, 1 1111001, 2 0100100, 3 0110000, 4 0011001, 5 0010010, 6 0000010, 7 1111000, 8 0000000, 9 0010000, A 0001000, b 0000011, C 1000110, d 0100001, E 0000110, F 0001110, blank 1111111.
- Two register sets:
  - Shadow (`value`/`dp_in`, `pending` flag): written on `load`. A later load overwrites it; the last one wins.
  - Active (drives the display): receives the shadow at frame wrap if `pending` is set, which then clears `pending`.
- Divider `cnt` counts 0..`SCAN_DIV`-1. At the terminal count `cnt` returns to 0 and digit index `idx` advances; `NUM_DIGITS`-1 wraps to 0. Wrap to 0 is the frame wrap.
- Leading-zero blanking: digit k is blanked when `blank_lz`=1, k≠0, and active nibbles k..`NUM_DIGITS`-1 are all 0. A blanked digit also forces `dp` off unless its own dp bit is set, in which case the dp stays lit.
- Anode: `an[idx]` is low only when `enable`=1 and `cnt` ≥ `GUARD`; otherwise `an` is all 1.

## Timing
- All outputs are registered. `seg`, `dp` and `an` reflect `idx`/`cnt` of the previous cycle, giving a fixed 1-cycle latency.
- Reset values: `seg`=7'h7F, `dp`=1, `an`=all 1, `frame_start`=0, `cnt`=0, `idx`=0, active and shadow = 0, `pending`=0.
  - First edge with `rst`=0: `cnt`→1 and outputs show digit 0 (anode off during guard); `frame_start` is not asserted for this partial slot.
- `frame_start`=1 in the cycle `seg` first shows digit 0 of a new frame.
- `load` in the same cycle as the frame-wrap edge: `value`/`dp_in` go directly to active, `pending` stays 0, and the new frame shows the new value.
- `load` at any other time: shown from the next frame start, never mid-frame, so there is no tearing.
- `rst` mid-frame: everything returns to reset values on that edge and any pending load is discarded.
- `enable` toggles take effect on the next edge. The scan position is unaffected.

## Structure
- Package `seg7_pkg`: 7-bit glyph localparams (`GLYPH_0`..`GLYPH_F`, `GLYPH_BLANK`, `GLYPH_ERR`) and the function `nibble_to_glyph(nibble, hex_mode)`.
- Sub-module `seg7_glyph`: combinational nibble + hex_mode + blank → 7-bit glyph. It is instantiated once on the muxed nibble.
- The top level holds the divider, index, shadow/active registers, LZ mask and output registers.

## Test plan
- Bench parameters: `NUM_DIGITS`=4, `SCAN_DIV`=8, `GUARD`=2.
- Reset then `load` `value`=16'h1234, `dp_in`=0: after the next `frame_start`, slots show `seg` 0011001, 0110000, 0100100, 1111001 for `idx` 0..3. Each `an` is low only for 6 of 8 cycles.
- `HEX_MODE`=1, `value`=16'hABEF: glyphs F 0001110, E 0000110, b 0000011, A 0001000. With `HEX_MODE`=0 all four digits show 0000110.
- `blank_lz`=1, `value`=16'h0050, `dp_in`=4'b1000: digits 0 and 1 show 0 and 5, digit 2 is blank, and digit 3 is blank with `dp`=0.
- `load` 16'h1111 mid-frame then 16'h2222 two cycles later: the current frame keeps the old value and the next frame shows 2222. A `load` on the wrap edge shows immediately in that frame.
- Assert `rst` during the slot for `idx`=2 with a pending load: the next edge gives `an`=4'hF, `seg`=7'h7F, and the display stays at 0 (the pending load is dropped).
- `enable`=0 for 20 cycles: `an`=4'hF throughout and `frame_start` keeps pulsing every 32 cycles.

Source files
------------

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - glyph constants and nibble-to-glyph decode for the 7-segment scan driver
package seg7_pkg;

    // Segment patterns, bit6..bit0 = g..a, active-low
    localparam logic [6:0] GLYPH_0     = 7'b1000000;
    localparam logic [6:0] GLYPH_1     = 7'b1111001;
    localparam logic [6:0] GLYPH_2     = 7'b0100100;
    localparam logic [6:0] GLYPH_3     = 7'b0110000;
    localparam logic [6:0] GLYPH_4     = 7'b0011001;
    localparam logic [6:0] GLYPH_5     = 7'b0010010;
    localparam logic [6:0] GLYPH_6     = 7'b0000010;
    localparam logic [6:0] GLYPH_7     = 7'b1111000;
    localparam logic [6:0] GLYPH_8     = 7'b0000000;
    localparam logic [6:0] GLYPH_9     = 7'b0010000;
    localparam logic [6:0] GLYPH_A     = 7'b0001000;
    localparam logic [6:0] GLYPH_B     = 7'b0000011;
    localparam logic [6:0] GLYPH_C     = 7'b1000110;
    localparam logic [6:0] GLYPH_D     = 7'b0100001;
    localparam logic [6:0] GLYPH_E     = 7'b0000110;
    localparam logic [6:0] GLYPH_F     = 7'b0001110;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
    localparam logic [6:0] GLYPH_ERR   = GLYPH_E;

    // Decimal digits always decode; 10..15 are letters in hex mode, otherwise the error glyph
    function automatic logic [6:0] nibble_to_glyph(input logic [3:0] nibble, input logic hex_mode);
        logic [6:0] g;
        case (nibble)
            4'h0:    g = GLYPH_0;
            4'h1:    g = GLYPH_1;
            4'h2:    g = GLYPH_2;
            4'h3:    g = GLYPH_3;
            4'h4:    g = GLYPH_4;
            4'h5:    g = GLYPH_5;
            4'h6:    g = GLYPH_6;
            4'h7:    g = GLYPH_7;
            4'h8:    g = GLYPH_8;
            4'h9:    g = GLYPH_9;
            4'hA:    g = hex_mode ? GLYPH_A : GLYPH_ERR;
            4'hB:    g = hex_mode ? GLYPH_B : GLYPH_ERR;
            4'hC:    g = hex_mode ? GLYPH_C : GLYPH_ERR;
            4'hD:    g = hex_mode ? GLYPH_D : GLYPH_ERR;
            4'hE:    g = hex_mode ? GLYPH_E : GLYPH_ERR;
            default: g = hex_mode ? GLYPH_F : GLYPH_ERR;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/seg7_glyph.sv
// rtl/seg7_glyph.sv - combinational nibble to segment-pattern decoder with blanking
import seg7_pkg::*;

module seg7_glyph (
    input  logic [3:0] nibble,
    input  logic       hex_mode,
    input  logic       blank,
    output logic [6:0] glyph
);

    // Blanking overrides whatever the nibble would decode to
    always_comb begin
        glyph = nibble_to_glyph(nibble, hex_mode);
        if (blank) begin
            glyph = GLYPH_BLANK;
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed N-digit common-anode 7-segment display driver
import seg7_pkg::*;

module seg7_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int GUARD      = 2,
    parameter bit HEX_MODE   = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic                      load,
    input  logic                      blank_lz,
    input  logic                      enable,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      frame_start
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_CNT = CNT_W'(GUARD);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    // Scan position
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic                      slot_end;
    logic                      frame_wrap;

    // Shadow set (written by load) and active set (drives the display)
    logic [4*NUM_DIGITS-1:0]   shadow_val_q, shadow_val_d;
    logic [NUM_DIGITS-1:0]     shadow_dp_q, shadow_dp_d;
    logic                      pending_q, pending_d;
    logic [4*NUM_DIGITS-1:0]   active_val_q, active_val_d;
    logic [NUM_DIGITS-1:0]     active_dp_q, active_dp_d;

    // Digit selection and leading-zero mask
    logic [NUM_DIGITS-1:0]     lz_mask;
    logic                      zero_run;
    logic [3:0]                cur_nibble;
    logic                      cur_dp;
    logic                      cur_blank;
    logic [6:0]                cur_glyph;

    // Registered outputs
    logic                      frame_wrap_q, frame_wrap_d;
    logic                      frame_start_q, frame_start_d;
    logic [6:0]                seg_q, seg_d;
    logic                      dp_q, dp_d;
    logic [NUM_DIGITS-1:0]     an_q, an_d;

    // Divider and digit index; the last slot of the last digit is the frame wrap
    always_comb begin
        slot_end   = (cnt_q == CNT_LAST);
        frame_wrap = slot_end && (idx_q == IDX_LAST);
        cnt_d      = cnt_q + CNT_W'(1);
        idx_d      = idx_q;
        if (slot_end) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Double buffering: loads land in the shadow and are promoted only at frame wrap,
    // except a load coinciding with the wrap, which goes straight to the active set
    always_comb begin
        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;
        pending_d    = pending_q;
        active_val_d = active_val_q;
        active_dp_d  = active_dp_q;
        if (frame_wrap) begin
            pending_d = 1'b0;
            if (load) begin
                active_val_d = value;
                active_dp_d  = dp_in;
            end else if (pending_q) begin
                active_val_d = shadow_val_q;
                active_dp_d  = shadow_dp_q;
            end
        end else if (load) begin
            shadow_val_d = value;
            shadow_dp_d  = dp_in;
            pending_d    = 1'b1;
        end
    end

    // Leading-zero mask from the top digit down, then select the digit being scanned
    always_comb begin
        zero_run   = 1'b1;
        lz_mask    = '0;
        cur_nibble = 4'h0;
        cur_dp     = 1'b0;
        cur_blank  = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run   = zero_run && (active_val_q[4*k +: 4] == 4'h0);
            lz_mask[k] = blank_lz && zero_run && (k != 0);
        end
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur_nibble = active_val_q[4*k +: 4];
                cur_dp     = active_dp_q[k];
                cur_blank  = lz_mask[k];
            end
        end
    end

    seg7_glyph u_glyph (
        .nibble   (cur_nibble),
        .hex_mode (HEX_MODE),
        .blank    (cur_blank),
        .glyph    (cur_glyph)
    );

    // Output stage: one cycle behind the scan position; anodes dark during the guard
    // interval so the previous digit's segments never ghost onto the new anode.
    // A blanked digit keeps its dp only when its own dp bit asks for it, which is
    // exactly the dp bit itself.
    always_comb begin
        seg_d         = cur_glyph;
        dp_d          = ~cur_dp;
        an_d          = '1;
        frame_wrap_d  = frame_wrap;
        frame_start_d = frame_wrap_q;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (enable && (cnt_q >= GUARD_CNT) && (idx_q == IDX_W'(k))) begin
                an_d[k] = 1'b0;
            end
        end
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            shadow_val_q  <= '0;
            shadow_dp_q   <= '0;
            pending_q     <= 1'b0;
            active_val_q  <= '0;
            active_dp_q   <= '0;
            frame_wrap_q  <= 1'b0;
            frame_start_q <= 1'b0;
            seg_q         <= GLYPH_BLANK;
            dp_q          <= 1'b1;
            an_q          <= '1;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            shadow_val_q  <= shadow_val_d;
            shadow_dp_q   <= shadow_dp_d;
            pending_q     <= pending_d;
            active_val_q  <= active_val_d;
            active_dp_q   <= active_dp_d;
            frame_wrap_q  <= frame_wrap_d;
            frame_start_q <= frame_start_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            an_q          <= an_d;
        end
    end

    assign seg         = seg_q;
    assign dp          = dp_q;
    assign an          = an_q;
    assign frame_start = frame_start_q;

endmodule
